disp_scan: RTL and testbench

DISP_SCAN -- requirements
Module: disp_scan

---
 rtl/disp_scan.sv | 109 ++++++++++
 tb/tb_disp_scan.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan.sv
// Four-digit multiplexed hex display scanner.
// Each digit slot lasts DIV cycles: GUARD all-off cycles, then the digit is lit.
// A new value (and the leading-zero blanking mode) is taken only at the frame
// boundary, so a frame always shows one consistent value.
module disp_scan #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned GUARD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic        ack,
  output logic [3:0]  digit,
  output logic [3:0]  dig_en_n,
  output logic        blank,
  output logic        frame_start
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD - 1);

  typedef enum logic {
    S_GUARD,
    S_ON
  } state_t;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  state_t        state;
  state_t        state_nx;
  logic [15:0]   shown;
  logic          lz;
  logic          slot_last;
  logic          boundary;
  logic          suppress;

  assign slot_last = (cnt == CNT_LAST);
  assign boundary  = slot_last && (idx == 2'd3);

  // Prescaler and slot index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_last) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Per-slot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_GUARD;
    else     state <= state_nx;
  end

  // Next state: the slot end wins, so every slot begins in GUARD.
  always_comb begin
    state_nx = state;
    if (slot_last)              state_nx = S_GUARD;
    else if (cnt == CNT_GUARD)  state_nx = S_ON;
  end

  // Frame-boundary capture of value and blanking mode, with acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shown <= '0;
      lz    <= 1'b0;
      ack   <= 1'b0;
    end else begin
      ack <= boundary && load;
      if (boundary) begin
        lz <= blank_lz;
        if (load) shown <= value;
      end
    end
  end

  // Leading-zero suppression: digit i is dark if it and all higher nibbles are zero.
  always_comb begin
    suppress = 1'b0;
    case (idx)
      2'd1:    suppress = lz && (shown[15:4]  == 12'h000);
      2'd2:    suppress = lz && (shown[15:8]  == 8'h00);
      2'd3:    suppress = lz && (shown[15:12] == 4'h0);
      default: suppress = 1'b0;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    digit = 4'h0;
    case (idx)
      2'd0:    digit = shown[3:0];
      2'd1:    digit = shown[7:4];
      2'd2:    digit = shown[11:8];
      default: digit = shown[15:12];
    endcase
    blank       = (state == S_GUARD) || suppress;
    dig_en_n    = blank ? '1 : ~(4'b0001 << idx);
    frame_start = (idx == 2'd0) && (cnt == '0);
  end

endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan with DIV=8, GUARD=2 (frame = 32 cycles).
// Stimulus pushes cycle-stamped expected outputs and expected ack cycles;
// a monitor on the falling edge pops and compares them.
module tb_disp_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        blank_lz = 1'b0;
  logic        ack;
  logic [3:0]  digit;
  logic [3:0]  dig_en_n;
  logic        blank;
  logic        frame_start;

  disp_scan #(.DIV(8), .GUARD(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value       (value),
    .blank_lz    (blank_lz),
    .ack         (ack),
    .digit       (digit),
    .dig_en_n    (dig_en_n),
    .blank       (blank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int unsigned tick = 0;
  always @(posedge clk) tick <= tick + 1;

  typedef struct {
    int unsigned t;
    logic [3:0]  d;
    logic [3:0]  en;
    logic        bl;
    logic        fs;
    logic        ak;
    string       nm;
  } exp_t;

  exp_t        expq[$];
  int unsigned ackq[$];
  int unsigned base;
  int unsigned scyc;
  int          seg;
  bit          done = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic ex(input int unsigned k, input logic [3:0] d, input logic [3:0] en,
                    input logic bl, input logic fs, input logic ak);
    exp_t e;
    e.t  = base + k;
    e.d  = d;
    e.en = en;
    e.bl = bl;
    e.fs = fs;
    e.ak = ak;
    e.nm = $sformatf("seg%0d_c%0d", seg, k);
    expq.push_back(e);
  endtask

  task automatic goto(input int unsigned k);
    while (scyc < k) begin
      @(posedge clk);
      #2;
      scyc++;
    end
  endtask

  // Monitor: compare everything due at this tick; finish once stimulus is done.
  always @(negedge clk) begin
    logic [10:0] g;
    logic [10:0] r;
    if (ack) begin
      total++;
      if (ackq.size() > 0 && ackq[0] == tick) begin
        void'(ackq.pop_front());
      end else begin
        bad++;
        $display("FAIL ack_pulse tick=%0d got ack=1 required ack=0", tick);
      end
    end
    for (int i = int'(expq.size()) - 1; i >= 0; i--) begin
      if (expq[i].t == tick) begin
        g = {digit, dig_en_n, blank, frame_start, ack};
        r = {expq[i].d, expq[i].en, expq[i].bl, expq[i].fs, expq[i].ak};
        total++;
        if (g !== r) begin
          bad++;
          $display("FAIL %s got digit=%h en=%b blank=%b fs=%b ack=%b required digit=%h en=%b blank=%b fs=%b ack=%b",
                   expq[i].nm, digit, dig_en_n, blank, frame_start, ack,
                   expq[i].d, expq[i].en, expq[i].bl, expq[i].fs, expq[i].ak);
        end
        expq.delete(i);
      end
    end
    if (done) begin
      foreach (ackq[i]) begin
        total++;
        bad++;
        $display("FAIL ack_missing tick=%0d got ack=0 required ack=1", ackq[i]);
      end
      foreach (expq[i]) begin
        total++;
        bad++;
        $display("FAIL %s got never_sampled required sampled", expq[i].nm);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #2;
    seg = 0;
    base = tick;
    ex(0, 4'h0, 4'b1111, 1'b1, 1'b1, 1'b0);

    // Segment 1: release reset; this cycle is cycle 0.
    @(posedge clk);
    #2;
    seg = 1;
    base = tick;
    scyc = 0;
    // frame 0: shown 0000
    ex(0,   4'h0, 4'b1111, 1, 1, 0);
    ex(1,   4'h0, 4'b1111, 1, 0, 0);
    ex(2,   4'h0, 4'b1110, 0, 0, 0);
    ex(7,   4'h0, 4'b1110, 0, 0, 0);
    ex(8,   4'h0, 4'b1111, 1, 0, 0);
    ex(10,  4'h0, 4'b1101, 0, 0, 0);
    // frame 1: A5C3 captured at end of cycle 31
    ex(32,  4'h3, 4'b1111, 1, 1, 1);
    ex(33,  4'h3, 4'b1111, 1, 0, 0);
    ex(34,  4'h3, 4'b1110, 0, 0, 0);
    ex(39,  4'h3, 4'b1110, 0, 0, 0);
    ex(40,  4'hC, 4'b1111, 1, 0, 0);
    ex(42,  4'hC, 4'b1101, 0, 0, 0);
    ex(47,  4'hC, 4'b1101, 0, 0, 0);
    ex(50,  4'h5, 4'b1011, 0, 0, 0);
    ex(55,  4'h5, 4'b1011, 0, 0, 0);
    ex(58,  4'hA, 4'b0111, 0, 0, 0);
    ex(63,  4'hA, 4'b0111, 0, 0, 0);
    // frames 2-3: mid-frame load pulse of FFFF is ignored
    ex(64,  4'h3, 4'b1111, 1, 1, 0);
    ex(84,  4'h5, 4'b1011, 0, 0, 0);
    ex(98,  4'h3, 4'b1110, 0, 0, 0);
    ex(106, 4'hC, 4'b1101, 0, 0, 0);
    // frames 4-5: load held across two boundaries recaptures each time
    ex(128, 4'h4, 4'b1111, 1, 1, 1);
    ex(129, 4'h4, 4'b1111, 1, 0, 0);
    ex(130, 4'h4, 4'b1110, 0, 0, 0);
    ex(138, 4'h3, 4'b1101, 0, 0, 0);
    ex(146, 4'h2, 4'b1011, 0, 0, 0);
    ex(154, 4'h1, 4'b0111, 0, 0, 0);
    ex(160, 4'h8, 4'b1111, 1, 1, 1);
    ex(162, 4'h8, 4'b1110, 0, 0, 0);
    ex(186, 4'h5, 4'b0111, 0, 0, 0);
    // frame 6: 0040 with leading-zero blanking
    ex(192, 4'h0, 4'b1111, 1, 1, 1);
    ex(194, 4'h0, 4'b1110, 0, 0, 0);
    ex(199, 4'h0, 4'b1110, 0, 0, 0);
    ex(200, 4'h4, 4'b1111, 1, 0, 0);
    ex(202, 4'h4, 4'b1101, 0, 0, 0);
    ex(208, 4'h0, 4'b1111, 1, 0, 0);
    ex(210, 4'h0, 4'b1111, 1, 0, 0);
    ex(215, 4'h0, 4'b1111, 1, 0, 0);
    ex(218, 4'h0, 4'b1111, 1, 0, 0);
    ex(223, 4'h0, 4'b1111, 1, 0, 0);
    // frame 7: 0000 with blanking, only digit 0 lights
    ex(224, 4'h0, 4'b1111, 1, 1, 1);
    ex(226, 4'h0, 4'b1110, 0, 0, 0);
    ex(234, 4'h0, 4'b1111, 1, 0, 0);
    ex(242, 4'h0, 4'b1111, 1, 0, 0);
    ex(250, 4'h0, 4'b1111, 1, 0, 0);
    // frame 8: A5C3 again, then reset asserted in slot 2 while lit
    ex(256, 4'h3, 4'b1111, 1, 1, 1);
    ex(258, 4'h3, 4'b1110, 0, 0, 0);
    ex(275, 4'h5, 4'b1011, 0, 0, 0);
    ex(276, 4'h0, 4'b1111, 1, 1, 0);
    ex(278, 4'h0, 4'b1111, 1, 1, 0);
    ackq.push_back(base + 32);
    ackq.push_back(base + 128);
    ackq.push_back(base + 160);
    ackq.push_back(base + 192);
    ackq.push_back(base + 224);
    ackq.push_back(base + 256);
    rst = 1'b0;

    goto(5);   value = 16'hA5C3; load = 1'b1;
    goto(32);  load = 1'b0;
    goto(76);  value = 16'hFFFF; load = 1'b1;
    goto(77);  load = 1'b0;
    goto(100); value = 16'h1234; load = 1'b1;
    goto(140); value = 16'h5678;
    goto(160); load = 1'b0;
    goto(165); blank_lz = 1'b1; value = 16'h0040; load = 1'b1;
    goto(192); load = 1'b0;
    goto(197); value = 16'h0000; load = 1'b1;
    goto(224); load = 1'b0;
    goto(228); blank_lz = 1'b0; value = 16'hA5C3; load = 1'b1;
    goto(256); load = 1'b0;
    goto(276); rst = 1'b1;
    goto(277); value = 16'h1111; load = 1'b1;
    goto(279);

    // Segment 2: release again with load high; nothing captured before the boundary.
    seg = 2;
    base = tick;
    scyc = 0;
    ex(0,  4'h0, 4'b1111, 1, 1, 0);
    ex(1,  4'h0, 4'b1111, 1, 0, 0);
    ex(2,  4'h0, 4'b1110, 0, 0, 0);
    ex(8,  4'h0, 4'b1111, 1, 0, 0);
    ex(10, 4'h0, 4'b1101, 0, 0, 0);
    ex(26, 4'h0, 4'b0111, 0, 0, 0);
    ex(32, 4'h0, 4'b1111, 1, 1, 0);
    ex(34, 4'h0, 4'b1110, 0, 0, 0);
    rst = 1'b0;
    goto(20); load = 1'b0;
    goto(40);
    done = 1'b1;
  end

endmodule
